// File: rtl/rr_arbiter_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package rr_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, REL} arb_state_t;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

endpackage

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: routes 'in' to the output chosen by 'sel', all others low.
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with bounded hold time and a dead cycle between grants.
module rr_arbiter8
  import rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               rel_pulse
);

  arb_state_t         state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [SEL_W-1:0]   ptr;
  logic               any_req;
  logic               leave;
  logic [SEL_W-1:0]   winner;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   p);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     idx;
    dbl = {r, r};
    rot = dbl[p +: NUM_REQ];
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
    return idx + p;
  endfunction

  assign any_req = |req;
  assign winner  = rr_pick(req, ptr);
  assign leave   = !req[sel] || (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (leave)   state_nxt = REL;
      REL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    rel_pulse = 1'b0;
    unique case (state)
      GRANT:   busy      = 1'b1;
      REL:     rel_pulse = 1'b1;
      default: ;
    endcase
  end

  // sel/ptr/hold_cnt only move at a decision or inside a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        sel      <= winner;
        hold_cnt <= '0;
      end else if (state == GRANT) begin
        if (leave) ptr      <= sel + SEL_W'(1);
        else       hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

  DMux8Way u_dmux (
    .in  (busy),
    .sel (sel),
    .a   (grant[0]),
    .b   (grant[1]),
    .c   (grant[2]),
    .d   (grant[3]),
    .e   (grant[4]),
    .f   (grant[5]),
    .g   (grant[6]),
    .h   (grant[7])
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: hold bound, early drop, fairness, wrap, late arrivals, async reset.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req, req1;
  logic [7:0] grant, grant1;
  logic [2:0] sel, sel1;
  logic       busy, busy1;
  logic       rel, rel1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .rel_pulse (rel)
  );

  rr_arbiter8 #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req1),
    .grant     (grant1),
    .sel       (sel1),
    .busy      (busy1),
    .rel_pulse (rel1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
      chk("inv_rel_busy", 32'(rel && busy), 32'd0);
      chk("inv_grant_busy", 32'((grant != 8'h00) && !busy), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    req1  = 8'h00;
    tick();
    chk("rst_grant", grant, 8'h00);
    chk("rst_sel", sel, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rel", rel, 1'b0);
    #2 reset = 1'b0;

    // Async reset in the middle of a grant
    do_reset();
    req = 8'h08;
    tick();
    chk("a_grant", grant, 8'h08);
    chk("a_sel", sel, 3'd3);
    #2 reset = 1'b1;
    #1;
    chk("a_rst_grant", grant, 8'h00);
    chk("a_rst_busy", busy, 1'b0);
    chk("a_rst_rel", rel, 1'b0);
    chk("a_rst_sel", sel, 3'd0);
    reset = 1'b0;
    tick();
    chk("a_regrant", grant, 8'h08);
    chk("a_resel", sel, 3'd3);
    req = 8'h00;

    // Steady hold of 4 cycles, plus MAX_HOLD=1 instance
    do_reset();
    req  = 8'h04;
    req1 = 8'h10;
    tick();
    chk("b_hold1", grant, 8'h04);
    chk("m1_grant", grant1, 8'h10);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("b_hold%0d", i), grant, 8'h04);
      if (i == 2) begin
        chk("m1_drop", grant1, 8'h00);
        chk("m1_rel", rel1, 1'b1);
        req1 = 8'h00;
      end
    end
    tick();
    chk("b_rel_grant", grant, 8'h00);
    chk("b_rel_pulse", rel, 1'b1);
    chk("b_rel_busy", busy, 1'b0);
    tick();
    chk("b_idle_grant", grant, 8'h00);
    chk("b_idle_rel", rel, 1'b0);
    chk("b_idle_sel", sel, 3'd2);
    tick();
    chk("b_regrant", grant, 8'h04);
    req = 8'h00;

    // Early drop after two grant cycles
    do_reset();
    req = 8'h01;
    tick();
    chk("c_g1", grant, 8'h01);
    tick();
    chk("c_g2", grant, 8'h01);
    req = 8'h00;
    tick();
    chk("c_rel_grant", grant, 8'h00);
    chk("c_rel_pulse", rel, 1'b1);
    req = 8'h03;
    tick();
    chk("c_idle", grant, 8'h00);
    tick();
    chk("c_ptr1", grant, 8'h02);
    req = 8'h00;

    // Fairness with everyone requesting
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk($sformatf("d_first%0d", g), grant, 8'h01 << (g % 8));
      tick();
      tick();
      tick();
      chk($sformatf("d_last%0d", g), grant, 8'h01 << (g % 8));
      tick();
      chk($sformatf("d_rel%0d", g), rel, 1'b1);
      tick();
      chk($sformatf("d_idle%0d", g), grant, 8'h00);
    end
    req = 8'h00;

    // Pointer wrap 7 -> 0
    do_reset();
    req = 8'h40;
    tick();
    chk("e_g6", grant, 8'h40);
    req = 8'h81;
    tick();
    chk("e_rel6", rel, 1'b1);
    tick();
    tick();
    chk("e_sel7", sel, 3'd7);
    chk("e_g7", grant, 8'h80);
    tick();
    tick();
    tick();
    tick();
    chk("e_rel7", rel, 1'b1);
    tick();
    tick();
    chk("e_sel0", sel, 3'd0);
    chk("e_g0", grant, 8'h01);
    req = 8'h00;

    // Late arrival ignored during grant
    do_reset();
    req = 8'h04;
    tick();
    chk("f_g2", grant, 8'h04);
    req = 8'h06;
    tick();
    chk("f_late1", grant, 8'h04);
    tick();
    chk("f_late2", grant, 8'h04);
    req = 8'h02;
    tick();
    chk("f_rel_grant", grant, 8'h00);
    chk("f_rel_pulse", rel, 1'b1);
    tick();
    chk("f_idle", grant, 8'h00);
    tick();
    chk("f_g1", grant, 8'h02);
    req = 8'h00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
